// File: rtl/window3x3_fp16.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register window over raster fp16 pixels.
// Optional macro WIN_STRIDE2_EN: emit only windows whose top-left corner sits on an even row and column.
module window3x3_fp16 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [15:0]      in_data,
    output logic [8:0][15:0] win,
    output logic             win_valid,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [15:0]      r_lb0 [IMG_W];
    logic [15:0]      r_lb1 [IMG_W];
    logic [8:0][15:0] r_tap;
    logic [8:0][15:0] r_win;
    logic             r_win_valid;
    logic             r_frame_done;

    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [8:0][15:0] w_tap_next;
    logic             w_emit;
    logic             w_last;

    // Position of the pixel on in_data; a start-of-frame beat is (0,0) whatever the counters say.
    always_comb begin
        w_col  = in_sof ? '0 : r_col;
        w_row  = in_sof ? '0 : r_row;
        w_last = (w_row == LAST_ROW) && (w_col == LAST_COL);
`ifdef WIN_STRIDE2_EN
        w_emit = (w_row >= RW'(2)) && (w_col >= CW'(2)) && !w_row[0] && !w_col[0];
`else
        w_emit = (w_row >= RW'(2)) && (w_col >= CW'(2));
`endif
    end

    always_comb begin
        w_tap_next = r_tap;
        for (int i = 0; i < 3; i++) begin
            w_tap_next[3*i]   = r_tap[3*i+1];
            w_tap_next[3*i+1] = r_tap[3*i+2];
        end
        w_tap_next[2] = r_lb1[IMG_W-1];
        w_tap_next[5] = r_lb0[IMG_W-1];
        w_tap_next[8] = in_data;
    end

    // Storage with no reset: stale contents never reach win because windows need two fresh rows.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb0[0] <= in_data;
            r_lb1[0] <= r_lb0[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                r_lb0[k] <= r_lb0[k-1];
                r_lb1[k] <= r_lb1[k-1];
            end
            r_tap <= w_tap_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= in_valid && w_emit;
            r_frame_done <= in_valid && w_last;
            if (in_valid) begin
                if (w_emit) begin
                    r_win <= w_tap_next;
                end
                if (w_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
        end
    end

    assign win        = r_win;
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_window3x3_fp16.sv
// Bench for window3x3_fp16 on a 5x4 image with pixel(r,c) = 16'h00RC; honours WIN_STRIDE2_EN.
`timescale 1ns/1ps
module tb_window3x3_fp16;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int EW = 146;  // {valid, frame_done, win}
`ifdef WIN_STRIDE2_EN
  localparam int WPF     = ((H - 1) / 2) * ((W - 1) / 2);
  localparam int PART_T5 = 1;  // windows from the partial frame before reset
`else
  localparam int WPF     = (H - 2) * (W - 2);
  localparam int PART_T5 = 2;
`endif

  typedef logic [8:0][15:0] win_t;
  typedef struct {
    logic [15:0] w0;
    logic [15:0] w6;
    logic [15:0] w8;
  } tv_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [15:0] in_data = '0;
  win_t        win;
  logic        win_valid;
  logic        frame_done;

  always #5 clk = ~clk;

  window3x3_fp16 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .win        (win),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  win_t          got_q[$];
  tv_t           tbl[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            win_cnt = 0;
  int            fd_cnt = 0;
  win_t          last_win = '0;
  win_t          t1_first = '0;
  bit            mon_en = 1'b0;

  function automatic logic [15:0] pix(input int r, input int c);
    return {8'h00, 4'(r), 4'(c)};
  endfunction

  function automatic win_t win_of(input int r, input int c);
    win_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[3*i+j] = pix(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  function automatic bit emits(input int r, input int c);
`ifdef WIN_STRIDE2_EN
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input int r, input int c, input bit sof);
    logic [EW-1:0] e;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = pix(r, c);
    e = {emits(r, c), (r == H - 1) && (c == W - 1), emits(r, c) ? win_of(r, c) : 144'h0};
    exp_q.push_back(e);
  endtask

  // Idle cycles carry junk data and a random sof, both of which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
    end
  endtask

  task automatic stream_frame(input bit sof, input int max_gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        beat(r, c, sof && (r == 0) && (c == 0));
        if (max_gap > 0) idle($urandom_range(0, max_gap));
      end
  endtask

  task automatic stream_until(input int r_end, input int c_end);
    for (int r = 0; r <= r_end; r++)
      for (int c = 0; c < W; c++)
        if ((r < r_end) || (c <= c_end)) beat(r, c, (r == 0) && (c == 0));
  endtask

  task automatic start_test();
    win_cnt = 0;
    fd_cnt  = 0;
    got_q.delete();
  endtask

  // ---------------- monitor: compare one cycle after each edge ----------------
  always @(posedge clk) begin
    bit            was_beat;
    logic [EW-1:0] e;
    was_beat = in_valid;
    #1;
    if (mon_en) begin
      if (was_beat) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty: got beat output with no expectation");
        end else begin
          e = exp_q.pop_front();
          chk("win_valid", 144'(win_valid), 144'(e[145]));
          chk("frame_done", 144'(frame_done), 144'(e[144]));
          if (e[145]) begin
            chk("win", win, e[143:0]);
            last_win = e[143:0];
          end else begin
            chk("win_hold_beat", win, last_win);
          end
        end
      end else begin
        chk("idle_win_valid", 144'(win_valid), 144'h0);
        chk("idle_frame_done", 144'(frame_done), 144'h0);
        chk("idle_win_hold", win, last_win);
      end
      if (win_valid) begin
        win_cnt++;
        got_q.push_back(win);
      end
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
`ifdef WIN_STRIDE2_EN
    tbl.push_back('{16'h0000, 16'h0020, 16'h0022});
    tbl.push_back('{16'h0002, 16'h0022, 16'h0024});
`else
    tbl.push_back('{16'h0000, 16'h0020, 16'h0022});
    tbl.push_back('{16'h0001, 16'h0021, 16'h0023});
    tbl.push_back('{16'h0002, 16'h0022, 16'h0024});
    tbl.push_back('{16'h0010, 16'h0030, 16'h0032});
    tbl.push_back('{16'h0011, 16'h0031, 16'h0033});
    tbl.push_back('{16'h0012, 16'h0032, 16'h0034});
`endif

    // Reset state
    #2;
    chk("reset_win", win, 144'h0);
    chk("reset_win_valid", 144'(win_valid), 144'h0);
    chk("reset_frame_done", 144'(frame_done), 144'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Test 1: back-to-back frame, checked against the constant table
    start_test();
    stream_frame(1'b1, 0);
    idle(3);
    chk("t1_window_count", 144'(win_cnt), 144'(WPF));
    chk("t1_frame_done_count", 144'(fd_cnt), 144'h1);
    for (int k = 0; k < tbl.size(); k++) begin
      if (k < got_q.size()) begin
        chk("t1_tbl_w0", 144'(got_q[k][0]), 144'(tbl[k].w0));
        chk("t1_tbl_w6", 144'(got_q[k][6]), 144'(tbl[k].w6));
        chk("t1_tbl_w8", 144'(got_q[k][8]), 144'(tbl[k].w8));
      end
    end
    if (got_q.size() > 0) t1_first = got_q[0];

    // Test 2: random gaps between beats
    start_test();
    stream_frame(1'b1, 3);
    idle(3);
    chk("t2_window_count", 144'(win_cnt), 144'(WPF));
    chk("t2_frame_done_count", 144'(fd_cnt), 144'h1);

    // Test 3: two frames, sof on each
    start_test();
    stream_frame(1'b1, 0);
    stream_frame(1'b1, 0);
    idle(3);
    chk("t3_window_count", 144'(win_cnt), 144'(2 * WPF));
    chk("t3_frame_done_count", 144'(fd_cnt), 144'h2);
    if (got_q.size() > WPF) chk("t3_second_first_win", got_q[WPF], t1_first);

    // Test 4: sof at (2,3) abandons the partial frame
    start_test();
    stream_until(2, 2);
    stream_frame(1'b1, 0);
    idle(3);
    chk("t4_window_count", 144'(win_cnt), 144'(1 + WPF));
    chk("t4_frame_done_count", 144'(fd_cnt), 144'h1);

    // Test 5: reset pulse mid-row 2, then a frame without sof
    start_test();
    stream_until(2, 3);
    idle(3);
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("t5_async_win", win, 144'h0);
    chk("t5_async_win_valid", 144'(win_valid), 144'h0);
    chk("t5_async_frame_done", 144'(frame_done), 144'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_win = '0;
    mon_en   = 1'b1;
    stream_frame(1'b0, 0);
    idle(3);
    chk("t5_window_count", 144'(win_cnt), 144'(PART_T5 + WPF));
    chk("t5_frame_done_count", 144'(fd_cnt), 144'h1);

    // Test 6: frame wrap with no sof and no idle cycle
    start_test();
    stream_frame(1'b1, 0);
    stream_frame(1'b0, 0);
    idle(3);
    chk("t6_window_count", 144'(win_cnt), 144'(2 * WPF));
    chk("t6_frame_done_count", 144'(fd_cnt), 144'h2);
    chk("t6_queue_drained", 144'(exp_q.size()), 144'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
